// File: rtl/mult_div_unit_pkg.sv
// Shared op codes, FSM states and result payload for the multiply/divide unit.
// Decode and hazard logic import the same constants.
package mult_div_unit_pkg;

   localparam int unsigned XLEN = 32;

   typedef enum logic [2:0] {
      MD_MULT  = 3'd0,
      MD_MULTU = 3'd1,
      MD_DIV   = 3'd2,
      MD_DIVU  = 3'd3,
      MD_MTHI  = 3'd4,
      MD_MTLO  = 3'd5
   } md_op_e;

   typedef enum logic {
      MD_IDLE = 1'b0,
      MD_RUN  = 1'b1
   } md_state_e;

   typedef struct packed {
      logic [XLEN-1:0] hi;
      logic [XLEN-1:0] lo;
   } md_res_t;

   function automatic logic is_mult(input logic [2:0] op);
      return (op == MD_MULT) || (op == MD_MULTU);
   endfunction

   function automatic logic is_div(input logic [2:0] op);
      return (op == MD_DIV) || (op == MD_DIVU);
   endfunction

endpackage

// File: rtl/md_compute.sv
// Combinational datapath: HI/LO result for each arithmetic op, plus a write
// enable that is dropped for divide-by-zero so HI/LO stay untouched.
module md_compute
   import mult_div_unit_pkg::*;
(
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output md_res_t         res_c,
   output logic            wr_c
);

   logic [2*XLEN-1:0] sprod;
   logic [2*XLEN-1:0] uprod;
   logic              b_zero;
   logic              div_ovf;
   logic [XLEN-1:0]   sdiv_b;
   logic [XLEN-1:0]   udiv_b;
   logic [XLEN-1:0]   squot;
   logic [XLEN-1:0]   srem;
   logic [XLEN-1:0]   uquot;
   logic [XLEN-1:0]   urem;

   // Low 64 bits of the product of sign-extended operands equal the signed product.
   assign sprod = {{XLEN{a[XLEN-1]}}, a} * {{XLEN{b[XLEN-1]}}, b};
   assign uprod = {{XLEN{1'b0}}, a} * {{XLEN{1'b0}}, b};

   assign b_zero  = (b == '0);
   assign div_ovf = (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);

   // MIN/-1 yields the same HI/LO as MIN/1, so both hazards divide by one.
   assign sdiv_b = (b_zero || div_ovf) ? XLEN'(1) : b;
   assign udiv_b = b_zero ? XLEN'(1) : b;

   assign squot = XLEN'($signed(a) / $signed(sdiv_b));
   assign srem  = XLEN'($signed(a) % $signed(sdiv_b));
   assign uquot = a / udiv_b;
   assign urem  = a % udiv_b;

   always_comb begin
      res_c = '0;
      wr_c  = 1'b0;
      case (op)
         MD_MULT: begin
            res_c = sprod;
            wr_c  = 1'b1;
         end
         MD_MULTU: begin
            res_c = uprod;
            wr_c  = 1'b1;
         end
         MD_DIV: begin
            res_c.hi = srem;
            res_c.lo = squot;
            wr_c     = !b_zero;
         end
         MD_DIVU: begin
            res_c.hi = urem;
            res_c.lo = uquot;
            wr_c     = !b_zero;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/mult_div_unit.sv
// E-stage multiply/divide unit: result captured in shadow registers at issue,
// committed to architectural HI/LO after a fixed latency.
module mult_div_unit
   import mult_div_unit_pkg::*;
#(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        mdStart,
   input  logic [2:0]  mdOp,
   input  logic [31:0] srcA,
   input  logic [31:0] srcB,
   input  logic        hiLoSel,
   output logic        busy,
   output logic [31:0] mulOut,
   output logic [31:0] hiOut,
   output logic [31:0] loOut
);

   localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

   md_state_e        state_q, state_d;
   logic [CNT_W-1:0] cnt_q,   cnt_d;
   logic [31:0]      hi_q,    hi_d;
   logic [31:0]      lo_q,    lo_d;
   md_res_t          sh_q,    sh_d;
   logic             wr_q,    wr_d;

   md_res_t res_c;
   logic    wr_c;

   md_compute u_md_compute (
      .op    (mdOp),
      .a     (srcA),
      .b     (srcB),
      .res_c (res_c),
      .wr_c  (wr_c)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= MD_IDLE;
         cnt_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         sh_q    <= '0;
         wr_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         sh_q    <= sh_d;
         wr_q    <= wr_d;
      end
   end

   // Issue in IDLE only; a start strobe during RUN is dropped, not queued.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      sh_d    = sh_q;
      wr_d    = wr_q;
      case (state_q)
         MD_IDLE: begin
            if (mdStart) begin
               if (is_mult(mdOp) || is_div(mdOp)) begin
                  sh_d    = res_c;
                  wr_d    = wr_c;
                  cnt_d   = is_mult(mdOp) ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
                  state_d = MD_RUN;
               end else if (mdOp == MD_MTHI) begin
                  hi_d = srcA;
               end else if (mdOp == MD_MTLO) begin
                  lo_d = srcA;
               end
            end
         end
         MD_RUN: begin
            if (cnt_q == CNT_W'(1)) begin
               cnt_d   = '0;
               state_d = MD_IDLE;
               if (wr_q) begin
                  hi_d = sh_q.hi;
                  lo_d = sh_q.lo;
               end
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: state_d = MD_IDLE;
      endcase
   end

   assign busy   = (state_q == MD_RUN);
   assign hiOut  = hi_q;
   assign loOut  = lo_q;
   assign mulOut = hiLoSel ? hi_q : lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit against a plain-arithmetic HI/LO model.
module tb_mult_div_unit;

   logic        clk;
   logic        reset;
   logic        mdStart;
   logic [2:0]  mdOp;
   logic [31:0] srcA;
   logic [31:0] srcB;
   logic        hiLoSel;
   logic        busy;
   logic [31:0] mulOut;
   logic [31:0] hiOut;
   logic [31:0] loOut;

   int checks = 0;
   int errors = 0;

   logic [31:0] hi_m;
   logic [31:0] lo_m;

   mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk     (clk),
      .reset   (reset),
      .mdStart (mdStart),
      .mdOp    (mdOp),
      .srcA    (srcA),
      .srcB    (srcB),
      .hiLoSel (hiLoSel),
      .busy    (busy),
      .mulOut  (mulOut),
      .hiOut   (hiOut),
      .loOut   (loOut)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int exp_cycles(input logic [2:0] op);
      if (op == 3'd0 || op == 3'd1) return 5;
      if (op == 3'd2 || op == 3'd3) return 10;
      return 0;
   endfunction

   // Architectural effect of one op on HI/LO, from plain integer arithmetic.
   task automatic model_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      int              sa;
      int              sb;
      longint          p;
      longint unsigned up;
      longint          q;
      longint          r;
      sa = a;
      sb = b;
      case (op)
         3'd0: begin
            p = longint'(sa) * longint'(sb);
            hi_m = p[63:32];
            lo_m = p[31:0];
         end
         3'd1: begin
            up = {32'd0, a} * {32'd0, b};
            hi_m = up[63:32];
            lo_m = up[31:0];
         end
         3'd2: if (b != 0) begin
            q = longint'(sa) / longint'(sb);
            r = longint'(sa) % longint'(sb);
            lo_m = q[31:0];
            hi_m = r[31:0];
         end
         3'd3: if (b != 0) begin
            lo_m = a / b;
            hi_m = a % b;
         end
         3'd4: hi_m = a;
         3'd5: lo_m = a;
         default: ;
      endcase
   endtask

   task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      mdStart = 1'b1;
      mdOp    = op;
      srcA    = a;
      srcB    = b;
      @(negedge clk);
      mdStart = 1'b0;
   endtask

   // Counts busy cycles from the first negedge after issue; bounded.
   task automatic count_busy(output int cyc);
      cyc = 0;
      while (busy === 1'b1 && cyc < 40) begin
         cyc++;
         @(negedge clk);
      end
   endtask

   task automatic test_reset;
      checks++;
      if (busy !== 1'b0 || hiOut !== 32'd0 || loOut !== 32'd0 || mulOut !== 32'd0) begin
         errors++;
         $display("FAIL reset: busy=%b hi=%h lo=%h mulOut=%h, want 0/0/0/0", busy, hiOut, loOut, mulOut);
      end
   endtask

   task automatic run_and_check(input string name, input logic [2:0] op,
                                input logic [31:0] a, input logic [31:0] b);
      int cyc;
      issue(op, a, b);
      model_op(op, a, b);
      count_busy(cyc);
      checks++;
      if (cyc !== exp_cycles(op)) begin
         errors++;
         $display("FAIL %s busy_cycles: got %0d, want %0d", name, cyc, exp_cycles(op));
      end
      checks++;
      if (hiOut !== hi_m || loOut !== lo_m) begin
         errors++;
         $display("FAIL %s hilo: got %h/%h, want %h/%h", name, hiOut, loOut, hi_m, lo_m);
      end
      hiLoSel = 1'b1;
      #1;
      checks++;
      if (mulOut !== hi_m) begin
         errors++;
         $display("FAIL %s mulOut_hi: got %h, want %h", name, mulOut, hi_m);
      end
      hiLoSel = 1'b0;
      #1;
      checks++;
      if (mulOut !== lo_m) begin
         errors++;
         $display("FAIL %s mulOut_lo: got %h, want %h", name, mulOut, lo_m);
      end
   endtask

   task automatic test_mult;
      run_and_check("mult_neg", 3'd0, 32'hFFFF_FFFE, 32'd3);
      checks++;
      if (hi_m !== 32'hFFFF_FFFF || lo_m !== 32'hFFFF_FFFA || loOut !== 32'hFFFF_FFFA) begin
         errors++;
         $display("FAIL mult_const: got %h/%h, want ffffffff/fffffffa", hiOut, loOut);
      end
   endtask

   task automatic test_multu;
      run_and_check("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      checks++;
      if (hiOut !== 32'hFFFF_FFFE || loOut !== 32'h0000_0001) begin
         errors++;
         $display("FAIL multu_const: got %h/%h, want fffffffe/00000001", hiOut, loOut);
      end
   endtask

   task automatic test_div;
      run_and_check("div_neg", 3'd2, 32'hFFFF_FFF9, 32'd2);
      checks++;
      if (hiOut !== 32'hFFFF_FFFF || loOut !== 32'hFFFF_FFFD) begin
         errors++;
         $display("FAIL div_const: got %h/%h, want ffffffff/fffffffd", hiOut, loOut);
      end
      run_and_check("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
      checks++;
      if (hiOut !== 32'h0 || loOut !== 32'h8000_0000) begin
         errors++;
         $display("FAIL div_ovf_const: got %h/%h, want 00000000/80000000", hiOut, loOut);
      end
   endtask

   task automatic test_div_zero;
      run_and_check("mthi", 3'd4, 32'h11, 32'h0);
      run_and_check("mtlo", 3'd5, 32'h22, 32'h0);
      run_and_check("divu_zero", 3'd3, 32'd7, 32'd0);
      checks++;
      if (hiOut !== 32'h11 || loOut !== 32'h22) begin
         errors++;
         $display("FAIL divu_zero_const: got %h/%h, want 00000011/00000022", hiOut, loOut);
      end
      run_and_check("div_zero", 3'd2, 32'hDEAD_BEEF, 32'd0);
   endtask

   task automatic test_undefined;
      run_and_check("undef6", 3'd6, 32'h1234_5678, 32'd9);
      run_and_check("undef7", 3'd7, 32'h8765_4321, 32'd3);
   endtask

   task automatic test_back_to_back;
      int cyc;
      issue(3'd0, 32'd6, 32'd7);
      model_op(3'd0, 32'd6, 32'd7);
      cyc = 0;
      while (busy === 1'b1 && cyc < 40) begin
         cyc++;
         if (cyc == 3) begin
            mdStart = 1'b1;
            mdOp    = 3'd2;
            srcA    = 32'd100;
            srcB    = 32'd1;
         end else begin
            mdStart = 1'b0;
         end
         @(negedge clk);
      end
      mdStart = 1'b0;
      checks++;
      if (cyc !== 5) begin
         errors++;
         $display("FAIL ignore_busy cycles: got %0d, want 5", cyc);
      end
      checks++;
      if (hiOut !== 32'd0 || loOut !== 32'd42) begin
         errors++;
         $display("FAIL ignore_busy hilo: got %h/%h, want 00000000/0000002a", hiOut, loOut);
      end
      repeat (3) @(negedge clk);
      checks++;
      if (busy !== 1'b0 || loOut !== 32'd42) begin
         errors++;
         $display("FAIL ignore_busy late: busy=%b lo=%h, want 0/0000002a", busy, loOut);
      end
   endtask

   task automatic test_reset_mid_run;
      run_and_check("pre_mthi", 3'd4, 32'h55, 32'h0);
      issue(3'd0, 32'd6, 32'd7);
      @(negedge clk);
      reset = 1'b1;
      #1;
      hi_m = 32'd0;
      lo_m = 32'd0;
      checks++;
      if (busy !== 1'b0 || hiOut !== 32'd0 || loOut !== 32'd0 || mulOut !== 32'd0) begin
         errors++;
         $display("FAIL reset_mid_run: busy=%b hi=%h lo=%h, want 0/0/0", busy, hiOut, loOut);
      end
      @(negedge clk);
      reset = 1'b0;
      repeat (8) @(negedge clk);
      checks++;
      if (busy !== 1'b0 || hiOut !== 32'd0 || loOut !== 32'd0) begin
         errors++;
         $display("FAIL reset_no_commit: busy=%b hi=%h lo=%h, want 0/0/0", busy, hiOut, loOut);
      end
   endtask

   task automatic test_random;
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      for (int i = 0; i < 30; i++) begin
         op = 3'($urandom_range(0, 7));
         a  = $urandom;
         b  = $urandom;
         case ($urandom_range(0, 5))
            0: b = 32'd0;
            1: begin
               a = 32'h8000_0000;
               b = 32'hFFFF_FFFF;
            end
            2: b = 32'($urandom_range(1, 9));
            default: ;
         endcase
         run_and_check("random", op, a, b);
      end
   endtask

   initial begin
      reset   = 1'b1;
      mdStart = 1'b0;
      mdOp    = 3'd0;
      srcA    = 32'd0;
      srcB    = 32'd0;
      hiLoSel = 1'b0;
      hi_m    = 32'd0;
      lo_m    = 32'd0;
      repeat (2) @(negedge clk);
      test_reset();
      reset = 1'b0;
      test_mult();
      test_multu();
      test_div();
      test_div_zero();
      test_undefined();
      test_back_to_back();
      test_reset_mid_run();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
